// File: rtl/types_pkg.sv
// Shared FSM state and grant types for the scratchpad DRAM responder.
package types_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_BUSY  = 2'd1,
    STORE_BUSY = 2'd2,
    RESP       = 2'd3
  } memresp_state_t;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memresp_grant_t;

  // State entered on a grant; a single-cycle latency skips the busy countdown.
  function automatic memresp_state_t grant_state(input memresp_grant_t g, input logic direct);
    if (direct) return RESP;
    return (g == LOAD) ? LOAD_BUSY : STORE_BUSY;
  endfunction

endpackage

// File: rtl/memresp_array.sv
// Word storage for the responder: one write port (store beats backdoor init), one async read port.
module memresp_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     st_wen_i,
  input  logic [$clog2(DEPTH)-1:0] st_idx_i,
  input  logic [DATA_W-1:0]        st_wdata_i,
  input  logic                     init_wen_i,
  input  logic [$clog2(DEPTH)-1:0] init_idx_i,
  input  logic [DATA_W-1:0]        init_wdata_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [DATA_W-1:0]        rd_data_c_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wen;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] wdata;

  // Store commit owns the port whenever it fires.
  always_comb begin
    wen   = st_wen_i | init_wen_i;
    widx  = st_wen_i ? st_idx_i : init_idx_i;
    wdata = st_wen_i ? st_wdata_i : init_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (wen) mem_q[widx] <= wdata;
  end

  assign rd_data_c_o = mem_q[rd_idx_i];

endmodule

// File: rtl/scratchpad_dram_responder.sv
// Fixed-latency load/store responder for the scratchpad external port, backed by memresp_array.
// Define MEMRESP_ERR_EN to flag out-of-range word indices (sticky addr_err) instead of wrapping.
module scratchpad_dram_responder
  import types_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     sLoad,
  input  logic [ADDR_W-1:0]        load_addr,
  output logic [DATA_W-1:0]        load_data,
  output logic                     sLoad_hit,
  input  logic                     sStore,
  input  logic [ADDR_W-1:0]        store_addr,
  input  logic [DATA_W-1:0]        store_data,
  output logic                     sStore_hit,
  input  logic                     init_wen,
  input  logic [$clog2(DEPTH)-1:0] init_addr,
  input  logic [DATA_W-1:0]        init_wdata,
  output logic                     addr_err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
  localparam int unsigned WIDX_W = ADDR_W - OFF_W;
  localparam int unsigned CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;

  memresp_state_t    state_q, state_d;
  memresp_grant_t    cur_q, cur_d;
  memresp_grant_t    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_hit_q, load_hit_d;
  logic              store_hit_q, store_hit_d;
  logic              addr_err_q, addr_err_d;

  logic              grant_load, grant_store;
  logic              req_held;
  logic              oor_d, oor_q;
  logic              st_wen;
  logic [DATA_W-1:0] rd_data;

  // Next-state: round-robin grant in IDLE, countdown/abort in BUSY, single RESP cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    widx_d       = widx_q;
    wdata_d      = wdata_q;
    grant_load   = sLoad && (!sStore || (last_grant_q == STORE));
    grant_store  = sStore && !grant_load;
    req_held     = (state_q == LOAD_BUSY) ? sLoad : sStore;

    case (state_q)
      IDLE: begin
        if (grant_load) begin
          cur_d   = LOAD;
          widx_d  = load_addr[ADDR_W-1:OFF_W];
          cnt_d   = CNT_W'(LAT - 1);
          state_d = grant_state(LOAD, LAT == 1);
        end else if (grant_store) begin
          cur_d   = STORE;
          widx_d  = store_addr[ADDR_W-1:OFF_W];
          wdata_d = store_data;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = grant_state(STORE, LAT == 1);
        end
      end
      LOAD_BUSY, STORE_BUSY: begin
        if (!req_held) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = cur_q;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEMRESP_ERR_EN
  assign oor_d = (widx_d >> IDX_W) != '0;
  assign oor_q = (widx_q >> IDX_W) != '0;
`else
  assign oor_d = 1'b0;
  assign oor_q = 1'b0;
`endif

  // Registered responses are computed for the cycle the FSM enters RESP.
  always_comb begin
    load_hit_d  = (state_d == RESP) && (cur_d == LOAD);
    store_hit_d = (state_d == RESP) && (cur_d == STORE);
    load_data_d = '0;
    if (load_hit_d && !oor_d) load_data_d = rd_data;
    addr_err_d = addr_err_q;
    if ((state_d == RESP) && oor_d) addr_err_d = 1'b1;
  end

  // Store lands at the edge that closes its RESP cycle.
  assign st_wen = (state_q == RESP) && (cur_q == STORE) && !oor_q;

  memresp_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i       (CLK),
    .st_wen_i    (st_wen),
    .st_idx_i    (widx_q[IDX_W-1:0]),
    .st_wdata_i  (wdata_q),
    .init_wen_i  (init_wen),
    .init_idx_i  (init_addr),
    .init_wdata_i(init_wdata),
    .rd_idx_i    (widx_d[IDX_W-1:0]),
    .rd_data_c_o (rd_data)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_q        <= LOAD;
      last_grant_q <= STORE;
      widx_q       <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_hit_q   <= 1'b0;
      store_hit_q  <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      widx_q       <= widx_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_hit_q   <= load_hit_d;
      store_hit_q  <= store_hit_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign load_data  = load_data_q;
  assign sLoad_hit  = load_hit_q;
  assign sStore_hit = store_hit_q;
  assign addr_err   = addr_err_q;

  // Byte-offset bits and index bits beyond the array only matter in the range-checked build.
  logic unused_ok;
  assign unused_ok = ^{load_addr[OFF_W-1:0], store_addr[OFF_W-1:0], widx_d, widx_q};

endmodule

// File: tb/tb_scratchpad_dram_responder.sv
// Directed scoreboard bench for scratchpad_dram_responder (LAT=4, DEPTH=64).
module tb_scratchpad_dram_responder;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned LAT    = 4;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
`ifdef MEMRESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              sLoad = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data;
  logic              sLoad_hit;
  logic              sStore = 1'b0;
  logic [ADDR_W-1:0] store_addr = '0;
  logic [DATA_W-1:0] store_data = '0;
  logic              sStore_hit;
  logic              init_wen = 1'b0;
  logic [IDX_W-1:0]  init_addr = '0;
  logic [DATA_W-1:0] init_wdata = '0;
  logic              addr_err;

  scratchpad_dram_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .sLoad(sLoad), .load_addr(load_addr), .load_data(load_data), .sLoad_hit(sLoad_hit),
    .sStore(sStore), .store_addr(store_addr), .store_data(store_data), .sStore_hit(sStore_hit),
    .init_wen(init_wen), .init_addr(init_addr), .init_wdata(init_wdata),
    .addr_err(addr_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        ldq[$];
  int          stq[$];
  logic [63:0] model [DEPTH];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [31:0] addr);
    logic [31:0] w;
    w = addr >> 3;
    if (ERR_EN && (w >= 32'(DEPTH))) return 64'd0;
    return model[w[IDX_W-1:0]];
  endfunction

  // Scoreboard: every hit pops the oldest expectation of its kind.
  always @(negedge CLK) begin
    exp_t e;
    if (sLoad_hit) begin
      if (ldq.size() == 0) check("unexpected_load_hit", 64'(sLoad_hit), 64'd0);
      else begin
        e = ldq.pop_front();
        check("load_hit_cycle", 64'(cyc), 64'(e.due));
        check("load_data", load_data, e.data);
      end
    end
    if (sStore_hit) begin
      if (stq.size() == 0) check("unexpected_store_hit", 64'(sStore_hit), 64'd0);
      else check("store_hit_cycle", 64'(cyc), 64'(stq.pop_front()));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic init_w(input int idx, input logic [63:0] d);
    init_wen   = 1'b1;
    init_addr  = IDX_W'(idx);
    init_wdata = d;
    model[idx] = d;
    tick();
    init_wen = 1'b0;
  endtask

  task automatic push_load(input logic [31:0] addr);
    load_addr = addr;
    sLoad     = 1'b1;
    ldq.push_back('{model_rd(addr), cyc + 1 + int'(LAT)});
  endtask

  task automatic push_store(input logic [31:0] addr, input logic [63:0] d, input int due);
    store_addr = addr;
    store_data = d;
    sStore     = 1'b1;
    stq.push_back(due);
    model[addr[IDX_W+2:3]] = d;
  endtask

  task automatic wait_hit(input bit is_load, input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(is_load ? sLoad_hit : sStore_hit) && n < 40);
    check({tag, "_seen"}, 64'(is_load ? sLoad_hit : sStore_hit), 64'd1);
  endtask

  task automatic drop(input bit is_load, input string tag);
    tick();
    if (is_load) sLoad = 1'b0;
    else sStore = 1'b0;
    @(negedge CLK);
    check({tag, "_pulse"}, 64'(is_load ? sLoad_hit : sStore_hit), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_load_hit", 64'(sLoad_hit), 64'd0);
    check("rst_store_hit", 64'(sStore_hit), 64'd0);
    check("rst_load_data", load_data, 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    init_w(5, 64'hDEAD_BEEF_0000_0005);
    init_w(0, 64'hA0A0_0000_0000_0000);
    init_w(30, 64'h3030);
    init_w(20, 64'h0);
    init_w(21, 64'h0);

    // First tie after reset goes to the load; store follows LAT+2 later.
    push_load(32'd40);
    push_store(32'd160, 64'h5555, cyc + 1 + 2 * int'(LAT) + 2);
    wait_hit(1'b1, "tie1_ld");
    drop(1'b1, "tie1_ld");
    wait_hit(1'b0, "tie1_st");
    drop(1'b0, "tie1_st");

    // Store was served last, so the second tie also goes to the load.
    tick();
    push_load(32'd160);
    push_store(32'd168, 64'h6666, cyc + 1 + 2 * int'(LAT) + 2);
    wait_hit(1'b1, "tie2_ld");
    drop(1'b1, "tie2_ld");
    wait_hit(1'b0, "tie2_st");
    drop(1'b0, "tie2_st");

    tick();
    push_load(32'd40);
    wait_hit(1'b1, "ld40");
    drop(1'b1, "ld40");

    // Store then immediately re-requested load of the same word.
    tick();
    push_store(32'h80, 64'h1234, cyc + 1 + int'(LAT));
    wait_hit(1'b0, "st80");
    tick();
    sStore = 1'b0;
    push_load(32'h80);
    wait_hit(1'b1, "ld80");
    drop(1'b1, "ld80");

    // Abort a load mid-flight, then a store must see full latency from a clean IDLE.
    tick();
    load_addr = 32'd40;
    sLoad = 1'b1;
    tick();
    tick();
    sLoad = 1'b0;
    tick();
    check("abort_no_hit", 64'(sLoad_hit), 64'd0);
    push_store(32'd168, 64'h7777, cyc + 1 + int'(LAT));
    wait_hit(1'b0, "post_abort_st");
    drop(1'b0, "post_abort_st");
    tick();
    push_load(32'd168);
    wait_hit(1'b1, "ld168");
    drop(1'b1, "ld168");

    // Reset during STORE_BUSY: no hit, word 30 keeps its init value.
    tick();
    store_addr = 32'd240;
    store_data = 64'hBAD0_BAD0;
    sStore = 1'b1;
    tick();
    tick();
    #2;
    nRST = 1'b0;
    #1;
    check("midrst_load_hit", 64'(sLoad_hit), 64'd0);
    check("midrst_store_hit", 64'(sStore_hit), 64'd0);
    check("midrst_load_data", load_data, 64'd0);
    check("midrst_addr_err", 64'(addr_err), 64'd0);
    sStore = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    push_load(32'd240);
    wait_hit(1'b1, "ld240");
    drop(1'b1, "ld240");

    // Word 128 is beyond the 64-word array: wraps to word 0, or flags when checked.
    tick();
    push_load(32'h400);
    wait_hit(1'b1, "ld_oor");
    drop(1'b1, "ld_oor");
    check("addr_err_after_oor", 64'(addr_err), 64'(ERR_EN));
    tick();
    push_load(32'd40);
    wait_hit(1'b1, "ld_after_oor");
    drop(1'b1, "ld_after_oor");
    check("addr_err_sticky", 64'(addr_err), 64'(ERR_EN));

    repeat (5) tick();
    check("load_queue_empty", 64'(ldq.size()), 64'd0);
    check("store_queue_empty", 64'(stq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
